// File: rtl/dma_pkg.sv
// Shared types for the DMA channel sequencer: FSM state encoding, transfer
// mode/type enums and the decoders that map raw per-channel fields onto them.
package dma_pkg;

  typedef enum logic [2:0] {
    SI_I = 3'd0,
    S0_I = 3'd1,
    S1_I = 3'd2,
    S2_I = 3'd3,
    S3_I = 3'd4,
    S4_I = 3'd5
  } state_idx_e;

  localparam int NUM_STATES = 6;
  typedef logic [NUM_STATES-1:0] state_t;

  localparam state_t ST_SI = 6'b000001;
  localparam state_t ST_S0 = 6'b000010;
  localparam state_t ST_S1 = 6'b000100;
  localparam state_t ST_S2 = 6'b001000;
  localparam state_t ST_S3 = 6'b010000;
  localparam state_t ST_S4 = 6'b100000;

  typedef enum logic [1:0] {
    DEMAND = 2'b00,
    SINGLE = 2'b01,
    BLOCK  = 2'b10
  } transfer_mode_e;

  typedef enum logic [1:0] {
    VERIFY = 2'b00,
    WRITE  = 2'b01,
    READ   = 2'b10
  } transfer_type_e;

  // Encoding 11 is folded onto single transfers.
  function automatic transfer_mode_e decode_mode(input logic [1:0] sel);
    case (sel)
      2'b00:   return DEMAND;
      2'b10:   return BLOCK;
      default: return SINGLE;
    endcase
  endfunction

  function automatic transfer_type_e decode_type(input logic [1:0] sel);
    case (sel)
      2'b01:   return WRITE;
      2'b10:   return READ;
      default: return VERIFY;
    endcase
  endfunction

endpackage

// File: rtl/dma_priority_arbiter.sv
// Request arbiter. Fixed priority (channel 0 highest) by default; with
// ROTATING_PRIORITY_EN the search starts at the rotation pointer.
module dma_priority_arbiter
  import dma_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter int CH_W   = $clog2(NUM_CH)
) (
  input  logic [NUM_CH-1:0] eligible,
  input  logic [CH_W-1:0]   pointer,
  output logic              valid,
  output logic [CH_W-1:0]   winner
);

  logic [CH_W-1:0] idx;

  assign valid = |eligible;

`ifdef ROTATING_PRIORITY_EN
  // Walk offsets downward so the channel closest to the pointer wins last.
  always_comb begin
    winner = '0;
    idx    = '0;
    for (int off = NUM_CH - 1; off >= 0; off--) begin
      idx = CH_W'((int'(pointer) + off) % NUM_CH);
      if (eligible[idx]) winner = idx;
    end
  end
`else
  logic unused_pointer;
  assign unused_pointer = ^pointer;

  always_comb begin
    winner = '0;
    idx    = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      idx = CH_W'(i);
      if (eligible[idx]) winner = idx;
    end
  end
`endif

endmodule

// File: rtl/dma_channel_sequencer.sv
// DMA timing/control sequencer: arbitration, HRQ/HLDA handshake and the
// SI..S4 transfer FSM. Optional feature macro: ROTATING_PRIORITY_EN.
module dma_channel_sequencer
  import dma_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter int CH_W   = $clog2(NUM_CH)
) (
  input  logic                  CLK,
  input  logic                  RESET,
  input  logic                  CS_N,
  input  logic [NUM_CH-1:0]     DREQ,
  input  logic [NUM_CH-1:0]     chMask,
  input  logic [2*NUM_CH-1:0]   modeSel,
  input  logic [2*NUM_CH-1:0]   transferType,
  input  logic [NUM_CH-1:0]     wordCountZero,
  input  logic                  HLDA,
  input  logic                  READY,
  input  logic [NUM_CH-1:0]     clearTc,
  output logic                  HRQ,
  output logic                  AEN,
  output logic                  ADSTB,
  output logic [NUM_CH-1:0]     DACK,
  output logic                  IOR_N,
  output logic                  IOW_N,
  output logic                  MEMR_N,
  output logic                  MEMW_N,
  output logic [CH_W-1:0]       activeCh,
  output logic                  programCondition,
  output logic                  loadAddr,
  output logic                  decrTemporaryWordCountReg,
  output logic                  incrTemporaryAddressReg,
  output logic                  updateCurrentWordCountReg,
  output logic                  updateCurrentAddressReg,
  output logic                  intEOP,
  output logic [NUM_CH-1:0]     tcStatus
);

  state_t          state, next_state;
  transfer_mode_e  mode_q;
  transfer_type_e  type_q;
  logic            wc_zero_q;
  logic [CH_W-1:0] pointer;
  logic [NUM_CH-1:0] eligible, active_onehot;
  logic            arb_valid, start, tc_hit;
  logic [CH_W-1:0] arb_winner;

  assign eligible      = DREQ & ~chMask & ~tcStatus;
  assign start         = state[SI_I] & arb_valid & CS_N;
  assign tc_hit        = state[S4_I] & wc_zero_q;
  assign active_onehot = NUM_CH'(1) << activeCh;

  dma_priority_arbiter #(
    .NUM_CH (NUM_CH),
    .CH_W   (CH_W)
  ) u_arbiter (
    .eligible (eligible),
    .pointer  (pointer),
    .valid    (arb_valid),
    .winner   (arb_winner)
  );

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) state <= ST_SI;
    else       state <= next_state;
  end

  // HLDA loss during S1..S3 abandons the cycle without commit strobes.
  always_comb begin
    next_state = state;
    case (1'b1)
      state[SI_I]: if (start) next_state = ST_S0;
      state[S0_I]: if (HLDA) next_state = ST_S1;
      state[S1_I]: next_state = HLDA ? ST_S2 : ST_SI;
      state[S2_I]: begin
        if (!HLDA)      next_state = ST_SI;
        else if (READY) next_state = ST_S4;
        else            next_state = ST_S3;
      end
      state[S3_I]: begin
        if (!HLDA)      next_state = ST_SI;
        else if (READY) next_state = ST_S4;
      end
      state[S4_I]: begin
        if (wc_zero_q) next_state = ST_SI;
        else begin
          case (mode_q)
            BLOCK:   next_state = ST_S1;
            DEMAND:  next_state = DREQ[activeCh] ? ST_S1 : ST_SI;
            default: next_state = ST_SI;
          endcase
        end
      end
      default: next_state = ST_SI;
    endcase
  end

  always_comb begin
    HRQ                       = state[S0_I] | state[S1_I] | state[S2_I] | state[S3_I] | state[S4_I];
    AEN                       = state[S1_I] | state[S2_I] | state[S3_I];
    ADSTB                     = state[S1_I];
    loadAddr                  = state[S1_I];
    DACK                      = AEN ? active_onehot : '0;
    IOR_N                     = 1'b1;
    IOW_N                     = 1'b1;
    MEMR_N                    = 1'b1;
    MEMW_N                    = 1'b1;
    decrTemporaryWordCountReg = state[S2_I];
    incrTemporaryAddressReg   = state[S2_I];
    updateCurrentWordCountReg = state[S4_I];
    updateCurrentAddressReg   = state[S4_I];
    intEOP                    = tc_hit;
    programCondition          = state[SI_I] & ~CS_N;
    if (state[S2_I] | state[S3_I]) begin
      case (type_q)
        WRITE: begin
          IOR_N  = 1'b0;
          MEMW_N = 1'b0;
        end
        READ: begin
          MEMR_N = 1'b0;
          IOW_N  = 1'b0;
        end
        default: ;
      endcase
    end
  end

  // Channel attributes are captured at arbitration so outputs depend only on state.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      activeCh  <= '0;
      mode_q    <= SINGLE;
      type_q    <= VERIFY;
      wc_zero_q <= 1'b0;
      pointer   <= '0;
      tcStatus  <= '0;
    end else begin
      if (start) begin
        activeCh <= arb_winner;
        mode_q   <= decode_mode(modeSel[{arb_winner, 1'b0} +: 2]);
        type_q   <= decode_type(transferType[{arb_winner, 1'b0} +: 2]);
      end
      wc_zero_q <= wordCountZero[activeCh];
      if (state[S4_I])
        pointer <= (activeCh == CH_W'(NUM_CH - 1)) ? '0 : activeCh + 1'b1;
      tcStatus <= (tcStatus & ~clearTc) | (tc_hit ? active_onehot : '0);
    end
  end

endmodule

// File: doc/dma_channel_sequencer.md
# dma_channel_sequencer

Parametrised timing-and-control sequencer for the DMA controller. It arbitrates among `NUM_CH` DREQ lines, runs the bus handshake (HRQ/HLDA), and steps an SI/S0/S1/S2/S3/S4 transfer FSM with READY-driven wait states. It supports single, block and demand transfer modes per channel, and strobes the internal register file to load, increment, decrement and commit the address and word-count registers. It sits between the bus interface and the internal register block, as the channel-generic successor of the fixed four-channel single-transfer controller.

## Interface
- `NUM_CH`, 4: number of channels (2..8).
- `CH_W`, `$clog2(NUM_CH)`: channel index width (derived; do not override).
- `CLK` in 1: clock. All state changes on rising edge.
- `RESET` in 1: one clock; reset is asynchronous and active-high.
- `CS_N` in 1: chip select, low = CPU programming access.
- `DREQ` in NUM_CH: per-channel request, active high.
- `chMask` in NUM_CH: 1 = channel masked.
- `modeSel` in 2*NUM_CH: per channel; 00 demand, 01 single, 10 block, 11 treated as single.
- `transferType` in 2*NUM_CH: per channel; 01 write (IO→mem), 10 read (mem→IO), 00/11 verify (no strobes).
- `wordCountZero` in NUM_CH: temporary word count of channel is 0.
- `HLDA` in 1: hold acknowledge.
- `READY` in 1: slow-device ready; low extends the command.
- `HRQ`, `AEN`, `ADSTB` out 1: hold request, address enable, address strobe.
- `DACK` out NUM_CH: one-hot acknowledge of the active channel.
- `IOR_N`, `IOW_N`, `MEMR_N`, `MEMW_N` out 1: command strobes, active low, driven (not tri-stated).
- `activeCh` out CH_W: index of the latched channel.
- `programCondition`, `loadAddr`, `decrTemporaryWordCountReg`, `incrTemporaryAddressReg`, `updateCurrentWordCountReg`, `updateCurrentAddressReg`, `intEOP` out 1: internal strobes.
- `tcStatus` out NUM_CH: sticky terminal-count flags.
- `clearTc` in NUM_CH: clears the matching `tcStatus` bits.

## Operation
- Reset values: state SI. HRQ, AEN, ADSTB and all strobes are 0. DACK is 0. Command strobes are 1. activeCh and tcStatus are 0. Rotation pointer is 0.
- Eligible request: `DREQ[i] & ~chMask[i] & ~tcStatus[i]`.
- SI: `programCondition` = `~CS_N`. Go to S0 when any channel is eligible and `CS_N`=1. The winner is latched into `activeCh` on this edge.
- S0: HRQ=1. Go to S1 on HLDA.
- S1: HRQ, AEN, ADSTB, loadAddr=1; DACK[activeCh]=1. Go to S2.
- S2: HRQ, AEN=1; DACK asserted. Command strobes per `transferType`. decrTemporaryWordCountReg and incrTemporaryAddressReg pulse for one cycle, in the first S2 cycle only. If READY=1 go to S4, else go to S3.
- S3: outputs as S2, no inc/dec pulses. Stay while READY=0; go to S4 on READY=1.
- S4: HRQ=1, AEN=0, DACK=0, strobes deasserted. updateCurrentWordCountReg and updateCurrentAddressReg=1.
  - If `wordCountZero[activeCh]`: intEOP=1, set `tcStatus[activeCh]`, go to SI.
  - Else if mode is single: go to SI.
  - Else if mode is block: go to S1.
  - Else if mode is demand and DREQ[activeCh]=1: go to S1; otherwise go to SI.
- HLDA falling in S1–S3: abort to SI. No update pulses, tcStatus unchanged.
- `clearTc` and a TC set on the same edge: set wins.
- A mask asserted mid-transfer takes effect at the next arbitration only.

## Timing
- Outputs are Moore-decoded from registered state. No input→output combinational paths except `programCondition` (from CS_N).
- Minimum single transfer, with HLDA already high: DREQ sampled at edge 0; S0 at 1; S1 at 2; S2 at 3; S4 at 4; SI at 5. Each wait cycle adds one S3 cycle.
- A block transfer of n words takes 3n cycles after the first S1.

## Configuration
- `ROTATING_PRIORITY_EN` defined: rotating priority. After S4 the serviced channel becomes lowest priority, i.e. pointer = activeCh+1 mod NUM_CH.
- Undefined: fixed priority, channel 0 highest; the pointer logic is not built.

## Structure
- Package `dma_pkg`:
  - state index enum and one-hot state typedef;
  - `transfer_mode_e` (DEMAND, SINGLE, BLOCK);
  - `transfer_type_e` (VERIFY, WRITE, READ).
- Sub-module `dma_priority_arbiter`: inputs are the eligible vector and the pointer; outputs are valid and the winner index. It holds the only `ROTATING_PRIORITY_EN` ifdef.

## Test plan
- DREQ=4'b0100, ch2 single/write, HLDA tied 1 → S0..S4 in 5 cycles. DACK=4'b0100 in S1–S2. IOR_N and MEMW_N low in S2 only. Return to SI.
- ch0 block, word count reaches zero after 3 words → three S1-S2-S4 loops without leaving hold, then intEOP pulse and tcStatus[0]=1. DREQ[0] held high produces no new request until clearTc[0].
- ch1 demand, DREQ dropped after the 2nd S4 → exactly 2 transfers, then SI.
- READY low for 3 cycles in S2 → three S3 cycles, strobes held low, exactly one decr/incr pulse.
- DREQ=4'b1111, each channel single → fixed order 0,0,0… without the macro; 0,1,2,3 with `ROTATING_PRIORITY_EN`.
- RESET asserted mid-S3, and HLDA dropped in S2 → immediate SI with all outputs at reset values; no update pulses.
